alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_if.sv | 27 ++
 rtl/alu_issue.sv | 119 +++++++++++
 tb/tb_alu_issue.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Instruction issue handshake between a requester and the alu_issue sequencer.
interface alu_issue_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_rd;
  logic [1:0] instr_rs1;
  logic [1:0] instr_rs2;

  modport master (
    output instr_valid,
    output instr_op,
    output instr_rd,
    output instr_rs1,
    output instr_rs2,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_op,
    input  instr_rd,
    input  instr_rs1,
    input  instr_rs2,
    output instr_ready
  );
endinterface

// File: rtl/alu_issue.sv
// Four-entry register file that feeds an external multi-cycle ALU: latches operands on issue,
// holds alu_en for ALU_LAT cycles, then writes the result and flags back.
module alu_issue #(
  parameter int unsigned ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  alu_issue_if.slave instr,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  output logic       alu_en,
  input  logic [7:0] alu_res,
  input  logic       alu_c,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  output logic [2:0] flags,
  output logic       done,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  localparam logic [2:0] LastCnt = 3'(ALU_LAT - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] rd_q, rd_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [2:0] flags_q, flags_d;
  logic [7:0] regs_q [4];
  logic [7:0] regs_d [4];
  logic       handshake;

  assign instr.instr_ready = (state_q == StIdle);
  assign handshake         = instr.instr_valid && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    flags_d = flags_q;
    regs_d  = regs_q;

    if (ld_en) begin
      regs_d[ld_addr] = ld_data;
    end

    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          // Operands come from regs_q, so a load on the same edge is not seen.
          a_d     = regs_q[instr.instr_rs1];
          b_d     = regs_q[instr.instr_rs2];
          op_d    = instr.instr_op;
          rd_d    = instr.instr_rd;
          cnt_d   = '0;
          state_d = StExec;
        end
      end
      StExec: begin
        if (cnt_q == LastCnt) begin
          state_d = StWb;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StWb: begin
        // Assigned after the load so writeback wins on an address collision.
        regs_d[rd_q] = alu_res;
        flags_d      = {alu_ovf, alu_zero, alu_c};
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      flags_q <= '0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      flags_q <= flags_d;
      regs_q  <= regs_d;
    end
  end

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_op  = op_q;
  assign alu_en  = (state_q == StExec);
  assign done    = (state_q == StWb);
  assign flags   = flags_q;
  assign rd_data = regs_q[rd_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: an in-bench ALU answers the DUT, a register model predicts
// results, and a monitor checks each writeback against the queued expectation.
module tb_alu_issue;
  localparam int unsigned L = 2;

  logic       clk;
  logic       rst;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic       alu_en;
  logic [7:0] alu_res;
  logic       alu_c, alu_zero, alu_ovf;
  logic [2:0] flags;
  logic       done;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;

  alu_issue_if u_if ();

  alu_issue #(
    .ALU_LAT(L)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (u_if),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_en  (alu_en),
    .alu_res (alu_res),
    .alu_c   (alu_c),
    .alu_zero(alu_zero),
    .alu_ovf (alu_ovf),
    .flags   (flags),
    .done    (done),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  typedef struct {
    logic [1:0] rd;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic [2:0] flg;
    int         hs;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] model_r [4];
  bit         pend;
  logic [1:0] pend_rd;
  logic [7:0] pend_res;
  int         cyc;
  int         en_cnt;
  int         errors;
  int         checks;

  // Returns {ovf, zero, carry, result}.
  function automatic logic [10:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] r;
    logic       v;
    r = '0;
    v = 1'b0;
    case (op)
      3'd0: r = {1'b0, a & b};
      3'd1: r = {1'b0, a | b};
      3'd2: r = {1'b0, a ^ b};
      3'd4: begin
        r = {1'b0, a} + {1'b0, b};
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd5: begin
        r = {1'b0, a} - {1'b0, b};
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd6: r = {a, 1'b0};
      3'd7: r = {a[0], 1'b0, a[7:1]};
      default: r = {1'b0, ~a};
    endcase
    return {v, (r[7:0] == 8'd0), r[8], r[7:0]};
  endfunction

  always_comb begin
    {alu_ovf, alu_zero, alu_c, alu_res} = alu_fn(alu_op, alu_a, alu_b);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_pending();
    if (pend) begin
      model_r[pend_rd] = pend_res;
      pend = 1'b0;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input bit keep, output int hs, output int busy);
    exp_t        e;
    logic [10:0] r;
    @(negedge clk);
    u_if.instr_op    = op;
    u_if.instr_rd    = rd;
    u_if.instr_rs1   = rs1;
    u_if.instr_rs2   = rs2;
    u_if.instr_valid = 1'b1;
    busy = 0;
    while (!u_if.instr_ready) begin
      busy++;
      if (busy > 50) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: instr_ready=0 for %0d cycles required 1", busy);
        u_if.instr_valid = 1'b0;
        hs = cyc;
        return;
      end
      @(negedge clk);
    end
    apply_pending();
    hs    = cyc;
    e.rd  = rd;
    e.a   = model_r[rs1];
    e.b   = model_r[rs2];
    e.op  = op;
    r     = alu_fn(op, e.a, e.b);
    e.res = r[7:0];
    e.flg = r[10:8];
    e.hs  = cyc;
    sb.push_back(e);
    pend     = 1'b1;
    pend_rd  = rd;
    pend_res = e.res;
    @(posedge clk);
    #1;
    if (!keep) u_if.instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!u_if.instr_ready) begin
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout: instr_ready=0 for %0d cycles required 1", n);
        break;
      end
      @(negedge clk);
    end
    apply_pending();
  endtask

  task automatic ld(input logic [1:0] a, input logic [7:0] d, input bit apply,
                    output logic saw_done);
    @(negedge clk);
    saw_done = done;
    ld_en    = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
    if (apply) model_r[a] = d;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), rd_data, model_r[i]);
    end
  endtask

  // Monitor: compares every writeback against the oldest queued expectation.
  initial begin
    en_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        en_cnt = 0;
      end else begin
        chk("no_en_in_idle", alu_en & u_if.instr_ready, 0);
        if (alu_en) en_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: got done=1 required 0 (no op outstanding)");
          end else begin
            mon_e = sb.pop_front();
            chk("alu_a", alu_a, mon_e.a);
            chk("alu_b", alu_b, mon_e.b);
            chk("alu_op", alu_op, mon_e.op);
            chk("en_cycles", en_cnt, L);
            chk("latency", cyc - mon_e.hs, L + 1);
            chk("ready_in_wb", u_if.instr_ready, 0);
            en_cnt = 0;
            @(negedge clk);
            if (rst) begin
              chk("flags", flags, mon_e.flg);
              chk("done_pulse", done, 0);
            end
          end
        end
      end
    end
  end

  initial begin
    int         hs_a, hs_b, busy;
    logic       sd;
    logic [1:0] rd, rs1, rs2;
    errors = 0;
    checks = 0;
    cyc    = 0;
    pend   = 1'b0;
    for (int i = 0; i < 4; i++) model_r[i] = '0;
    rst              = 1'b0;
    ld_en            = 1'b0;
    ld_addr          = '0;
    ld_data          = '0;
    rd_addr          = '0;
    u_if.instr_valid = 1'b0;
    u_if.instr_op    = '0;
    u_if.instr_rd    = '0;
    u_if.instr_rs1   = '0;
    u_if.instr_rs2   = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", u_if.instr_ready, 1);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", flags, 0);
    chk("rst_operands", {alu_a, alu_b, alu_op}, 0);
    check_regs("rst");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_after_release", u_if.instr_ready, 1);

    // 0x0F + 0x01 into R3
    ld(2'd1, 8'h0F, 1'b1, sd);
    ld(2'd2, 8'h01, 1'b1, sd);
    issue(3'b100, 2'd3, 2'd1, 2'd2, 1'b0, hs_a, busy);
    wait_idle();
    rd_addr = 2'd3;
    #1;
    chk("add_r3", rd_data, 8'h10);
    chk("add_flags", flags, 3'b000);
    check_regs("add");

    // 0xFF + 0x01 into R0: zero and carry
    ld(2'd1, 8'hFF, 1'b1, sd);
    issue(3'b100, 2'd0, 2'd1, 2'd2, 1'b0, hs_a, busy);
    wait_idle();
    rd_addr = 2'd0;
    #1;
    chk("wrap_r0", rd_data, 8'h00);
    chk("wrap_flags", flags, 3'b011);

    // Valid held high across two instructions
    ld(2'd2, 8'h33, 1'b1, sd);
    issue(3'b101, 2'd1, 2'd2, 2'd3, 1'b1, hs_a, busy);
    issue(3'b010, 2'd2, 2'd1, 2'd2, 1'b0, hs_b, busy);
    chk("b2b_spacing", hs_b - hs_a, L + 2);
    chk("b2b_busy_cycles", busy, L + 1);
    wait_idle();
    check_regs("b2b");

    // Load to the writeback target during WB is dropped
    issue(3'b001, 2'd3, 2'd1, 2'd2, 1'b0, hs_a, busy);
    repeat (L) @(negedge clk);
    ld(2'd3, 8'hA5, 1'b0, sd);
    chk("wb_cycle_same", sd, 1);
    wait_idle();
    check_regs("wb_same");
    // Load to another register during WB is kept
    issue(3'b110, 2'd3, 2'd2, 2'd1, 1'b0, hs_a, busy);
    repeat (L) @(negedge clk);
    ld(2'd0, 8'h5A, 1'b1, sd);
    chk("wb_cycle_other", sd, 1);
    wait_idle();
    check_regs("wb_other");

    // Load to a source during EXEC does not disturb latched operands
    ld(2'd1, 8'h21, 1'b1, sd);
    issue(3'b100, 2'd2, 2'd1, 2'd0, 1'b0, hs_a, busy);
    ld(2'd1, 8'hC3, 1'b1, sd);
    rd_addr = 2'd1;
    #1;
    chk("exec_ld_debug", rd_data, 8'hC3);
    wait_idle();
    check_regs("exec_ld");

    // Reset during EXEC aborts the operation
    issue(3'b100, 2'd2, 2'd1, 2'd3, 1'b0, hs_a, busy);
    #2;
    chk("abort_pre_en", alu_en, 1);
    rst = 1'b0;
    #1;
    chk("abort_alu_en", alu_en, 0);
    chk("abort_ready", u_if.instr_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_flags", flags, 0);
    chk("abort_operands", {alu_a, alu_b, alu_op}, 0);
    sb.delete();
    pend = 1'b0;
    for (int i = 0; i < 4; i++) model_r[i] = '0;
    check_regs("abort");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready_rel", u_if.instr_ready, 1);
    @(negedge clk);
    chk("abort_ready_next", u_if.instr_ready, 1);
    chk("abort_no_done", done, 0);

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < $urandom_range(0, 2); k++) begin
        ld(2'($urandom_range(0, 3)), 8'($urandom), 1'b1, sd);
      end
      rd  = 2'($urandom_range(0, 3));
      rs1 = 2'($urandom_range(0, 3));
      rs2 = 2'($urandom_range(0, 3));
      issue(3'($urandom_range(0, 7)), rd, rs1, rs2, 1'b0, hs_a, busy);
      if ($urandom_range(0, 3) == 0) begin
        ld(2'($urandom_range(0, 3)), 8'($urandom), 1'b1, sd);
      end
      wait_idle();
      check_regs($sformatf("rnd%0d", n));
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
